// File: rtl/twohot_pkg.sv
// Shared definitions for the two-hot stream decoder: code count and codeword builder.
package twohot_pkg;

    localparam int unsigned DefaultM = 5;
    // Widest codeword the builder function can produce.
    localparam int unsigned MaxM     = 32;

    // Number of distinct 2-of-m codewords.
    function automatic int unsigned ncodes(input int unsigned m);
        return m * (m - 1) / 2;
    endfunction

    // Codeword k: bits i>j set, ordered by i ascending then j ascending; zero if k is out of range.
    function automatic logic [MaxM-1:0] code_of(input int unsigned m, input int unsigned k);
        logic [MaxM-1:0] code;
        int unsigned     cnt;
        code = '0;
        cnt  = 0;
        for (int unsigned i = 1; i < MaxM; i++) begin
            for (int unsigned j = 0; j < i; j++) begin
                if (i < m) begin
                    if (cnt == k) begin
                        code[i] = 1'b1;
                        code[j] = 1'b1;
                    end
                    cnt++;
                end
            end
        end
        return code;
    endfunction

endpackage

// File: rtl/twohot_idx2code.sv
// Combinational index -> two-hot codeword lookup with range check.
module twohot_idx2code
    import twohot_pkg::*;
#(
    parameter int unsigned M = DefaultM,
    parameter int unsigned W = $clog2(M * (M - 1) / 2)
) (
    input  logic [W-1:0] idx,
    output logic [M-1:0] code,
    output logic         bad
);

    localparam int unsigned    NCodes  = ncodes(M);
    localparam int unsigned    Entries = 2 ** W;
    localparam logic [W:0]     NCodesW = (W + 1)'(NCodes);

    // Table is sized to the full index space; entries beyond the last code are zero.
    logic [M-1:0] rom [Entries];

    for (genvar k = 0; k < Entries; k++) begin : g_rom
        localparam logic [MaxM-1:0] Full = code_of(M, k);
        assign rom[k] = Full[M-1:0];
    end

    // Look up the codeword and flag indices past the last valid code.
    always_comb begin
        bad  = ({1'b0, idx} >= NCodesW);
        code = bad ? '0 : rom[idx];
    end

endmodule

// File: rtl/twohot_stream_dec.sv
// Registered two-hot decoder with valid/ready handshake and an internal generate counter.
// Optional error counter enabled by defining TWOHOT_STREAM_ERRCNT_EN.
module twohot_stream_dec
    import twohot_pkg::*;
#(
    parameter int unsigned M  = DefaultM,
    parameter int unsigned W  = $clog2(M * (M - 1) / 2),
    parameter int unsigned CW = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          mode,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [W-1:0]  in_idx,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [M-1:0]  out_code,
    output logic          out_err,
    output logic [CW-1:0] err_cnt
);

    localparam int unsigned  NCodes  = ncodes(M);
    localparam logic [W-1:0] LastIdx = W'(NCodes - 1);

    logic         accept;
    logic [W-1:0] sel_idx;
    logic [M-1:0] dec_code;
    logic         dec_bad;
    logic         beat_err;

    logic         out_valid_q, out_valid_d;
    logic [M-1:0] out_code_q, out_code_d;
    logic         out_err_q, out_err_d;
    logic [W-1:0] gen_cnt_q, gen_cnt_d;

    assign in_ready = rst_n && (!out_valid_q || out_ready);
    assign accept   = in_valid && in_ready;
    assign sel_idx  = mode ? gen_cnt_q : in_idx;
    // The counter never leaves range, so only decode beats can be erroneous.
    assign beat_err = !mode && dec_bad;

    twohot_idx2code #(
        .M (M),
        .W (W)
    ) u_idx2code (
        .idx  (sel_idx),
        .code (dec_code),
        .bad  (dec_bad)
    );

    // Next state for the output register and generate counter.
    always_comb begin
        out_valid_d = out_valid_q;
        out_code_d  = out_code_q;
        out_err_d   = out_err_q;
        gen_cnt_d   = gen_cnt_q;
        if (accept) begin
            out_valid_d = 1'b1;
            out_code_d  = dec_code;
            out_err_d   = beat_err;
            if (mode) begin
                gen_cnt_d = (gen_cnt_q == LastIdx) ? '0 : gen_cnt_q + W'(1);
            end
        end else if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            out_code_q  <= '0;
            out_err_q   <= 1'b0;
            gen_cnt_q   <= '0;
        end else begin
            out_valid_q <= out_valid_d;
            out_code_q  <= out_code_d;
            out_err_q   <= out_err_d;
            gen_cnt_q   <= gen_cnt_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_code  = out_code_q;
    assign out_err   = out_err_q;

`ifdef TWOHOT_STREAM_ERRCNT_EN
    logic [CW-1:0] err_cnt_q, err_cnt_d;

    // Saturating count of accepted erroneous beats.
    always_comb begin
        err_cnt_d = err_cnt_q;
        if (accept && beat_err && (err_cnt_q != {CW{1'b1}})) begin
            err_cnt_d = err_cnt_q + CW'(1);
        end
    end

    // Error counter register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            err_cnt_q <= '0;
        end else begin
            err_cnt_q <= err_cnt_d;
        end
    end

    assign err_cnt = err_cnt_q;
`else
    assign err_cnt = '0;
`endif

endmodule

// File: tb/tb_twohot_stream_dec.sv
// Self-checking bench for twohot_stream_dec (M=5, CW=2).
module tb_twohot_stream_dec;

`ifdef TWOHOT_STREAM_ERRCNT_EN
    localparam bit CntEn = 1'b1;
`else
    localparam bit CntEn = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst_n;
    logic       mode;
    logic       in_valid;
    logic       in_ready;
    logic [3:0] in_idx;
    logic       out_valid;
    logic       out_ready;
    logic [4:0] out_code;
    logic       out_err;
    logic [1:0] err_cnt;

    int total  = 0;
    int passed = 0;

    typedef struct {
        logic       mode;
        logic [3:0] idx;
        logic [4:0] code;
        logic       err;
    } vec_t;

    vec_t       vecs [12];
    logic [4:0] codes [10];

    twohot_stream_dec #(
        .M  (5),
        .W  (4),
        .CW (2)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .mode      (mode),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_idx    (in_idx),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_code  (out_code),
        .out_err   (out_err),
        .err_cnt   (err_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] exp_cnt(input int n);
        if (!CntEn) return 0;
        return (n > 3) ? 3 : n;
    endfunction

    task automatic do_reset();
        rst_n    = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b1;
        tick();
        rst_n = 1'b1;
    endtask

    initial begin
        codes = '{5'b00011, 5'b00101, 5'b00110, 5'b01001, 5'b01010,
                  5'b01100, 5'b10001, 5'b10010, 5'b10100, 5'b11000};
        for (int k = 0; k < 10; k++) vecs[k] = '{1'b0, 4'(k), codes[k], 1'b0};
        vecs[10] = '{1'b0, 4'd12, 5'b00000, 1'b1};
        vecs[11] = '{1'b0, 4'd15, 5'b00000, 1'b1};

        // Reset state
        rst_n = 1'b0; mode = 1'b0; in_valid = 1'b1; in_idx = 4'd0; out_ready = 1'b1;
        #1;
        chk("rst_in_ready", 32'(in_ready), 0);
        tick();
        tick();
        chk("rst_out_valid", 32'(out_valid), 0);
        chk("rst_out_code", 32'(out_code), 0);
        chk("rst_out_err", 32'(out_err), 0);
        chk("rst_err_cnt", 32'(err_cnt), 0);
        rst_n = 1'b1;

        // Decode sweep and range errors, back-to-back
        for (int v = 0; v < 12; v++) begin
            mode = vecs[v].mode; in_idx = vecs[v].idx; in_valid = 1'b1;
            tick();
            chk($sformatf("vec%0d_valid", v), 32'(out_valid), 1);
            chk($sformatf("vec%0d_code", v), 32'(out_code), 32'(vecs[v].code));
            chk($sformatf("vec%0d_err", v), 32'(out_err), 32'(vecs[v].err));
        end
        chk("range_err_cnt", 32'(err_cnt), exp_cnt(2));
        in_valid = 1'b0;
        tick();
        chk("drain_valid", 32'(out_valid), 0);

        // Backpressure
        do_reset();
        mode = 1'b0; in_valid = 1'b1; in_idx = 4'd3; out_ready = 1'b0;
        tick();
        in_idx = 4'd4;
        for (int c = 0; c < 4; c++) begin
            chk("bp_in_ready", 32'(in_ready), 0);
            tick();
            chk("bp_valid", 32'(out_valid), 1);
            chk("bp_code", 32'(out_code), 32'(5'b01001));
        end
        out_ready = 1'b1;
        #1;
        chk("bp_release_ready", 32'(in_ready), 1);
        tick();
        chk("bp_next_valid", 32'(out_valid), 1);
        chk("bp_next_code", 32'(out_code), 32'(5'b01010));
        in_valid = 1'b0;
        tick();
        chk("bp_drain", 32'(out_valid), 0);

        // Generate wrap over 12 beats
        do_reset();
        mode = 1'b1; in_idx = 4'd0; in_valid = 1'b1;
        for (int b = 0; b < 12; b++) begin
            tick();
            chk($sformatf("gen%0d_code", b), 32'(out_code), 32'(codes[b % 10]));
            chk($sformatf("gen%0d_err", b), 32'(out_err), 0);
        end
        in_valid = 1'b0;
        tick();
        mode = 1'b0; in_idx = 4'd7; in_valid = 1'b1;
        tick();
        chk("switch_dec_code", 32'(out_code), 32'(5'b10010));
        mode = 1'b1; in_idx = 4'd0;
        tick();
        chk("switch_gen_code", 32'(out_code), 32'(5'b00110));

        // Saturation of the error counter
        do_reset();
        mode = 1'b0; in_idx = 4'd13; in_valid = 1'b1;
        for (int n = 1; n <= 5; n++) begin
            tick();
            chk($sformatf("sat%0d_err", n), 32'(out_err), 1);
            chk($sformatf("sat%0d_code", n), 32'(out_code), 0);
            chk($sformatf("sat%0d_cnt", n), 32'(err_cnt), exp_cnt(n));
        end

        // Reset mid-stream with a held beat
        do_reset();
        mode = 1'b0; in_idx = 4'd14; in_valid = 1'b1;
        tick();
        mode = 1'b1;
        tick();
        tick();
        chk("mid_pre_code", 32'(out_code), 32'(5'b00101));
        chk("mid_pre_cnt", 32'(err_cnt), exp_cnt(1));
        out_ready = 1'b0;
        tick();
        chk("mid_held_valid", 32'(out_valid), 1);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_in_ready", 32'(in_ready), 0);
        tick();
        chk("mid_rst_valid", 32'(out_valid), 0);
        chk("mid_rst_code", 32'(out_code), 0);
        chk("mid_rst_cnt", 32'(err_cnt), 0);
        rst_n = 1'b1; out_ready = 1'b1;
        tick();
        chk("mid_first_gen", 32'(out_code), 32'(5'b00011));
        chk("mid_first_valid", 32'(out_valid), 1);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
